soc_seq_uart_top: RTL and testbench

Top-level demo SoC block: a tiny micro-sequencer executes a fixed instruction ROM that transmits the ASCII string "HELLO\n" once over a transmit-only 8N1 UART, then halts. It is the FPGA top: driven directly by the board 50 MHz oscillator and reset button, and its only output is the UART TX pin.

---
 rtl/soc_seq_uart_top.sv | 146 ++++++++++++++
 tb/tb_soc_seq_uart_top.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/soc_seq_uart_top.sv
// Demo SoC top: a micro-sequencer plays a fixed ROM program that sends "HELLO\n"
// once over a transmit-only 8N1 UART, then halts until the next reset.
module soc_seq_uart_top #(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned BAUD_RATE = 115200
) (
    input  logic clk_50mhz,
    input  logic rst_btn,
    output logic uart_txd
);
    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int unsigned CntW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CntW-1:0] CntReload = CntW'(CLKS_PER_BIT - 1);
    localparam logic [1:0] OpSend = 2'b01;

    typedef enum logic [1:0] {SqFetch, SqExec, SqWait, SqHalted} seq_state_e;
    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;

    seq_state_e      seq_state_q, seq_state_d;
    logic [2:0]      pc_q, pc_d;
    logic [9:0]      instr_q, instr_d;
    tx_state_e       tx_state_q, tx_state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            txd_q, txd_d;
    logic            tx_start, tx_busy;
    logic [7:0]      tx_data;

    function automatic logic [9:0] rom_word(input logic [2:0] addr);
        case (addr)
            3'd0:    rom_word = {OpSend, 8'h48};
            3'd1:    rom_word = {OpSend, 8'h45};
            3'd2:    rom_word = {OpSend, 8'h4C};
            3'd3:    rom_word = {OpSend, 8'h4C};
            3'd4:    rom_word = {OpSend, 8'h4F};
            3'd5:    rom_word = {OpSend, 8'h0A};
            default: rom_word = 10'h000;
        endcase
    endfunction

    always_ff @(posedge clk_50mhz) begin
        if (rst_btn) begin
            seq_state_q <= SqFetch;
            pc_q        <= 3'd0;
            instr_q     <= 10'h000;
            tx_state_q  <= TxIdle;
            cnt_q       <= '0;
            bit_idx_q   <= 3'd0;
            shreg_q     <= 8'h00;
            txd_q       <= 1'b1;
        end else begin
            seq_state_q <= seq_state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            tx_state_q  <= tx_state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            txd_q       <= txd_d;
        end
    end

    // Sequencer: unknown opcodes fall through to HALT.
    always_comb begin
        seq_state_d = seq_state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        case (seq_state_q)
            SqFetch: begin
                instr_d     = rom_word(pc_q);
                seq_state_d = SqExec;
            end
            SqExec: begin
                if (instr_q[9:8] == OpSend) begin
                    pc_d        = pc_q + 3'd1;
                    seq_state_d = SqWait;
                end else begin
                    seq_state_d = SqHalted;
                end
            end
            SqWait:  if (!tx_busy) seq_state_d = SqFetch;
            default: ;
        endcase
    end

    always_comb begin
        tx_start = (seq_state_q == SqExec) && (instr_q[9:8] == OpSend);
        tx_data  = instr_q[7:0];
    end

    always_comb begin
        tx_state_d = tx_state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shreg_d    = shreg_q;
        case (tx_state_q)
            TxIdle: begin
                if (tx_start) begin
                    shreg_d    = tx_data;
                    cnt_d      = CntReload;
                    tx_state_d = TxStart;
                end
            end
            TxStart: begin
                if (cnt_q == '0) begin
                    cnt_d      = CntReload;
                    bit_idx_d  = 3'd0;
                    tx_state_d = TxData;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            TxData: begin
                if (cnt_q == '0) begin
                    cnt_d = CntReload;
                    if (bit_idx_q == 3'd7) begin
                        tx_state_d = TxStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shreg_d   = {1'b0, shreg_q[7:1]};
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: begin
                if (cnt_q == '0) tx_state_d = TxIdle;
                else cnt_d = cnt_q - CntW'(1);
            end
        endcase
    end

    // Line level is registered from the upcoming state so the pin never glitches.
    always_comb begin
        tx_busy = (tx_state_q != TxIdle);
        case (tx_state_d)
            TxStart: txd_d = 1'b0;
            TxData:  txd_d = shreg_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    assign uart_txd = txd_q;

endmodule

// File: tb/tb_soc_seq_uart_top.sv
// Bench for soc_seq_uart_top: cycle-exact frame checks against a byte scoreboard,
// start-up latency, inter-frame gaps, reset hold, mid-character reset and post-halt idle.
module tb_soc_seq_uart_top;
    localparam int CPB   = 434;
    localparam int FRAME = 10 * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic txd;

    soc_seq_uart_top dut (
        .clk_50mhz(clk),
        .rst_btn  (rst),
        .uart_txd (txd)
    );

    always #10 clk = ~clk;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] exp_q[$];
    logic [7:0] msg[6] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h0A};
    int         gaps[5];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_msg();
        foreach (msg[i]) exp_q.push_back(msg[i]);
    endtask

    // Counts high negedge samples before the line is seen low; bounded.
    task automatic wait_fall(input int bound, output int highs, output bit found);
        int n;
        highs = 0;
        found = 1'b0;
        n     = 0;
        while (!found && n < bound) begin
            @(negedge clk);
            if (txd === 1'b0) found = 1'b1;
            else highs++;
            n++;
        end
    endtask

    // Entered on the first negedge of a start bit; checks every cycle of the frame.
    task automatic check_frame(input string tag);
        logic [7:0] exp_b, got;
        logic       lvl, stopbit;
        int         bad, k;
        exp_b   = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        got     = 8'h00;
        stopbit = 1'b0;
        bad     = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (i > 0) @(negedge clk);
            if (i < CPB) lvl = 1'b0;
            else if (i >= 9 * CPB) lvl = 1'b1;
            else lvl = exp_b[(i - CPB) / CPB];
            if (txd !== lvl) bad++;
            if (i % CPB == CPB / 2) begin
                k = i / CPB;
                if (k >= 1 && k <= 8) got[k-1] = txd;
                if (k == 9) stopbit = txd;
            end
        end
        check({tag, " byte"}, got, exp_b);
        check({tag, " bit_timing"}, bad, 0);
        check({tag, " stop_bit"}, stopbit, 1);
    endtask

    task automatic check_startup(input string tag);
        int highs;
        bit found;
        wait_fall(8, highs, found);
        check({tag, " startup_within_4"}, (found && highs + 1 <= 4), 1);
    endtask

    task automatic run_msg(input string tag);
        int highs;
        bit found;
        check_startup(tag);
        for (int f = 0; f < 6; f++) begin
            if (f > 0) begin
                wait_fall(10, highs, found);
                gaps[f-1] = highs;
                check($sformatf("%s gap%0d_1to3", tag, f), (found && highs >= 1 && highs <= 3), 1);
            end
            check_frame($sformatf("%s frame%0d", tag, f));
        end
        for (int g = 1; g < 5; g++) check($sformatf("%s gap%0d_equal", tag, g), gaps[g], gaps[0]);
        check({tag, " scoreboard_drained"}, exp_q.size(), 0);
    endtask

    task automatic post_halt(input string tag, input int n);
        int lows;
        lows = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
        check({tag, " idle_after_halt"}, lows, 0);
    endtask

    initial begin
        int bad, highs;
        bit found;

        // Long reset: line must stay high throughout.
        rst = 1'b1;
        bad = 0;
        repeat (10000) begin
            @(negedge clk);
            if (txd !== 1'b1) bad++;
        end
        check("reset_hold_high", bad, 0);

        push_msg();
        rst = 1'b0;
        run_msg("msg1");
        post_halt("msg1", 3000);

        // Restart, then a one-cycle reset in the middle of the first 'L'.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("restart_reset_txd", txd, 1);
        rst = 1'b0;
        exp_q.delete();
        push_msg();
        check_startup("msg2");
        check_frame("msg2 frame0");
        wait_fall(10, highs, found);
        check_frame("msg2 frame1");
        wait_fall(10, highs, found);
        check("msg2 L_start_seen", found, 1);
        repeat (2300) @(negedge clk);
        check("msg2 mid_L_bit4_low", txd, 0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_reset_txd_high", txd, 1);
        rst = 1'b0;
        exp_q.delete();
        push_msg();
        run_msg("msg3");
        post_halt("msg3", 3000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
